yolo_axis_mm2s_gen: RTL and testbench
=====================================

# yolo_axis_mm2s_gen

DMA-side AXI4-Stream transmitter that drives the yolo top's `S_AXIS_MM2S_*` slave port in place of the AXI DMA MM2S channel. It is used for bring-up and regression of the input-stream rate adapter. On command it emits one frame of deterministic, seed-based pattern beats, with programmable inter-beat gaps and a partial last beat. It obeys AXIS master rules under arbitrary `TREADY` back-pressure.

## Interface
Parameters:
- `TBITS`, 64, stream data width; must be a multiple of 32.
- `TBYTE`, 8, keep width; equals `TBITS/8`.

Ports:
- `aclk`  in  1  — the only clock.
- `aresetn`  in  1  — asynchronous, active-low reset.
- `cmd_start`  in  1  — single-cycle frame request; ignored while `cmd_busy`=1.
- `cmd_len`  in  16  — frame length in beats; 0 is a null frame.
- `cmd_tail_bytes`  in  $clog2(TBYTE)  — valid bytes in the last beat; 0 means all `TBYTE` bytes.
- `cmd_gap`  in  4  — idle cycles inserted after each accepted non-last beat.
- `cmd_seed`  in  32  — pattern base value.
- `cmd_busy`  out  1  — high from the cycle after an accepted `cmd_start` until the frame completes.
- `cmd_done`  out  1  — one-cycle pulse when a frame completes.
- `frames_sent`  out  16  — count of completed frames, including null frames; wraps at 16 bits.
- `M_AXIS_MM2S_TVALID`  out  1  — AXIS valid.
- `M_AXIS_MM2S_TREADY`  in  1  — AXIS ready.
- `M_AXIS_MM2S_TDATA`  out  TBITS  — beat data.
- `M_AXIS_MM2S_TKEEP`  out  TBYTE  — byte enables.
- `M_AXIS_MM2S_TLAST`  out  1  — end of frame.

## Operation
- All command fields are latched on an accepted `cmd_start`. Input changes after that have no effect on the frame in progress.
- FSM states: IDLE, SEND, GAP.
  - IDLE, `cmd_start` with `cmd_len`≠0: go to SEND; `cmd_busy`=1.
  - IDLE, `cmd_start` with `cmd_len`=0: stay in IDLE; `cmd_done` pulses the next cycle; `frames_sent` increments; no beats are sent.
  - SEND: `TVALID`=1. On handshake (`TVALID & TREADY`):
    - last beat → IDLE, pulse `cmd_done`, increment `frames_sent`;
    - otherwise, if gap≠0 → GAP, with the gap counter loaded to `cmd_gap`;
    - otherwise stay in SEND and advance to the next beat.
  - GAP: `TVALID`=0. The counter decrements each cycle; on reaching 1 go to SEND. Total `TVALID`-low time is exactly `cmd_gap` cycles.
- Beat index `i` runs from 0 to `cmd_len`−1. Each 32-bit lane `k` (k=0 at LSB) of `TDATA` is `seed + i*(TBITS/32) + k`, modulo 2^32.
- `TKEEP` is all ones except on the last beat, where it is the low `cmd_tail_bytes` bits set (all ones if 0). Bytes outside `TKEEP` carry the pattern anyway.
- `TLAST` is 1 only on beat `cmd_len`−1. A frame of length 1 has `TLAST`=1 on its only beat.
- AXIS rule: while `TVALID`=1 and `TREADY`=0, `TDATA`, `TKEEP` and `TLAST` hold and `TVALID` stays high.
- `TREADY` held high with `cmd_gap`=0 gives one beat per cycle with no bubbles.

## Timing
- Reset: state IDLE. `TVALID`, `TLAST`, `cmd_busy`, `cmd_done` = 0. `TDATA` = 0, `TKEEP` = 0, `frames_sent` = 0.
- Reset asserted mid-frame aborts the frame immediately (asynchronous). `TVALID` drops without `TLAST`; this is the only permitted AXIS violation.
- All outputs are registered. `cmd_start` in cycle N gives `TVALID`=1 and `cmd_busy`=1 in cycle N+1.
- Last handshake in cycle M: `cmd_done`=1 and `cmd_busy`=0 in M+1, with the updated `frames_sent` in M+1.
- The earliest next `cmd_start` is accepted in cycle M+1, giving back-to-back frames with one idle cycle between them.
- `cmd_start` while busy is dropped, with no queuing.
- A `cmd_start` in the same cycle as the last handshake is dropped.
- `frames_sent` wraps from 0xFFFF to 0x0000.

## Structure
- Shared package `yolo_axis_pkg`: the FSM state enum, default `TBITS`/`TBYTE` constants, and function `tail_keep(tail_bytes)` returning the `TKEEP` mask.
- One sub-module, `yolo_axis_lane_pattern`: combinational lane generator taking (seed, beat index) and producing `TBITS` of data. The top registers its output.
- Target size: about 150–200 lines of RTL.

## Test plan
- Len 4, seed 0x100, gap 0, tail 0, `TREADY`=1 → 4 consecutive beats. Beat 0 `TDATA` = 0x00000101_00000100, beat 3 = 0x00000107_00000106. `TKEEP` = 0xFF on all beats. `TLAST` on beat 3 only. `cmd_done` one cycle later. `frames_sent` = 1.
- Len 3, tail 3, random `TREADY` at 30% → data/keep/last stable during every stall. Last `TKEEP` = 0x07. Exactly 3 handshakes.
- Len 5, gap 2, `TREADY`=1 → `TVALID` pattern 1,0,0,1,0,0,1,0,0,1,0,0,1. `cmd_done` after the 5th beat.
- Len 0 → no `TVALID`. `cmd_done` pulses once. `frames_sent` increments. Then len 1 → single beat with `TLAST`=1.
- `cmd_start` pulsed mid-frame and again on the last-handshake cycle → both ignored. A start in the done cycle is accepted; the next frame starts 1 cycle later.
- `aresetn` low during beat 2 of a len-8 frame → `TVALID` low the same cycle; all outputs at reset values. A new len-2 frame after release → correct beats, `frames_sent`=1.

Source files
------------

// File: rtl/yolo_axis_pkg.sv
// Shared types and helpers for the MM2S-side AXIS pattern generator.
// Holds the FSM encoding, default stream widths and the last-beat keep mask.
package yolo_axis_pkg;

    localparam int TBITS_DEF = 64;
    localparam int TBYTE_DEF = TBITS_DEF / 8;
    localparam int KEEP_MAX  = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } mm2s_state_e;

    // Low tail_bytes bits set; tail_bytes of 0 means a full beat of nbytes.
    function automatic logic [KEEP_MAX-1:0] tail_keep(input logic [7:0] tail_bytes,
                                                      input int         nbytes);
        logic [KEEP_MAX-1:0] m;
        for (int b = 0; b < KEEP_MAX; b++) begin
            if (tail_bytes == 8'd0) m[b] = (b < nbytes);
            else                    m[b] = (b < int'(tail_bytes));
        end
        return m;
    endfunction

endpackage

// File: rtl/yolo_axis_lane_pattern.sv
// Combinational beat pattern: lane k of beat i carries seed + i*LANES + k.
// The caller registers the result.
module yolo_axis_lane_pattern #(
    parameter int TBITS = 64
) (
    input  logic [31:0]      seed_i,
    input  logic [15:0]      beat_i,
    output logic [TBITS-1:0] data_o
);

    localparam int LANES = TBITS / 32;

    logic [31:0] base;
    assign base = seed_i + 32'(beat_i) * 32'(LANES);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign data_o[k*32 +: 32] = base + 32'(k);
    end

endmodule

// File: rtl/yolo_axis_mm2s_gen.sv
// AXIS master standing in for the DMA MM2S channel: emits one seeded pattern
// frame per command, with programmable inter-beat gaps and a partial last beat.
module yolo_axis_mm2s_gen
    import yolo_axis_pkg::*;
#(
    parameter int TBITS = TBITS_DEF,
    parameter int TBYTE = TBITS / 8
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     cmd_start,
    input  logic [15:0]              cmd_len,
    input  logic [$clog2(TBYTE)-1:0] cmd_tail_bytes,
    input  logic [3:0]               cmd_gap,
    input  logic [31:0]              cmd_seed,
    output logic                     cmd_busy,
    output logic                     cmd_done,
    output logic [15:0]              frames_sent,
    output logic                     M_AXIS_MM2S_TVALID,
    input  logic                     M_AXIS_MM2S_TREADY,
    output logic [TBITS-1:0]         M_AXIS_MM2S_TDATA,
    output logic [TBYTE-1:0]         M_AXIS_MM2S_TKEEP,
    output logic                     M_AXIS_MM2S_TLAST
);

    localparam int TW = $clog2(TBYTE);

    mm2s_state_e      state_q, state_d;
    logic [15:0]      len_q, len_d;
    logic [TW-1:0]    tail_q, tail_d;
    logic [3:0]       gap_q, gap_d;
    logic [31:0]      seed_q, seed_d;
    logic [15:0]      beat_q, beat_d;
    logic [3:0]       gcnt_q, gcnt_d;
    logic             tvalid_q, tvalid_d;
    logic [TBITS-1:0] tdata_q, tdata_d;
    logic [TBYTE-1:0] tkeep_q, tkeep_d;
    logic             tlast_q, tlast_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [15:0]      frames_q, frames_d;

    // The beat about to be loaded is beat 0 of a new command from IDLE,
    // otherwise the successor of the beat being handed off.
    logic             is_idle;
    logic [31:0]      nxt_seed;
    logic [15:0]      nxt_idx;
    logic [15:0]      nxt_last_idx;
    logic [TW-1:0]    nxt_tail;
    logic             nxt_is_last;
    logic [TBYTE-1:0] nxt_keep;
    logic [TBITS-1:0] nxt_data;

    assign is_idle      = (state_q == ST_IDLE);
    assign nxt_seed     = is_idle ? cmd_seed       : seed_q;
    assign nxt_idx      = is_idle ? 16'd0          : beat_q + 16'd1;
    assign nxt_last_idx = is_idle ? cmd_len - 16'd1 : len_q - 16'd1;
    assign nxt_tail     = is_idle ? cmd_tail_bytes : tail_q;
    assign nxt_is_last  = (nxt_idx == nxt_last_idx);
    assign nxt_keep     = nxt_is_last ? TBYTE'(tail_keep(8'(nxt_tail), TBYTE)) : '1;

    yolo_axis_lane_pattern #(.TBITS(TBITS)) u_pattern (
        .seed_i (nxt_seed),
        .beat_i (nxt_idx),
        .data_o (nxt_data)
    );

    always_comb begin
        logic load;
        state_d  = state_q;
        len_d    = len_q;
        tail_d   = tail_q;
        gap_d    = gap_q;
        seed_d   = seed_q;
        beat_d   = beat_q;
        gcnt_d   = gcnt_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        frames_d = frames_q;
        load     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    len_d  = cmd_len;
                    tail_d = cmd_tail_bytes;
                    gap_d  = cmd_gap;
                    seed_d = cmd_seed;
                    beat_d = 16'd0;
                    if (cmd_len != 16'd0) begin
                        state_d  = ST_SEND;
                        tvalid_d = 1'b1;
                        busy_d   = 1'b1;
                        load     = 1'b1;
                    end else begin
                        done_d   = 1'b1;
                        frames_d = frames_q + 16'd1;
                    end
                end
            end
            ST_SEND: begin
                if (M_AXIS_MM2S_TREADY) begin
                    if (tlast_q) begin
                        state_d  = ST_IDLE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        frames_d = frames_q + 16'd1;
                    end else begin
                        beat_d = nxt_idx;
                        load   = 1'b1;
                        if (gap_q != 4'd0) begin
                            state_d  = ST_GAP;
                            gcnt_d   = gap_q;
                            tvalid_d = 1'b0;
                        end
                    end
                end
            end
            ST_GAP: begin
                // Next beat is already loaded; only the valid is withheld.
                if (gcnt_q == 4'd1) begin
                    state_d  = ST_SEND;
                    tvalid_d = 1'b1;
                end else begin
                    gcnt_d = gcnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            tdata_d = nxt_data;
            tkeep_d = nxt_keep;
            tlast_d = nxt_is_last;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            tail_q   <= '0;
            gap_q    <= '0;
            seed_q   <= '0;
            beat_q   <= '0;
            gcnt_q   <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            tail_q   <= tail_d;
            gap_q    <= gap_d;
            seed_q   <= seed_d;
            beat_q   <= beat_d;
            gcnt_q   <= gcnt_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            frames_q <= frames_d;
        end
    end

    assign cmd_busy           = busy_q;
    assign cmd_done           = done_q;
    assign frames_sent        = frames_q;
    assign M_AXIS_MM2S_TVALID = tvalid_q;
    assign M_AXIS_MM2S_TDATA  = tdata_q;
    assign M_AXIS_MM2S_TKEEP  = tkeep_q;
    assign M_AXIS_MM2S_TLAST  = tlast_q;

endmodule

// File: tb/tb_yolo_axis_mm2s_gen.sv
// Scoreboard bench for yolo_axis_mm2s_gen: frames are modelled as beat lists
// at issue time, and a monitor checks every handshake, stall, gap and done.
module tb_yolo_axis_mm2s_gen;

    localparam int TBITS = 64;
    localparam int TBYTE = 8;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_start;
    logic [15:0] cmd_len;
    logic [2:0]  cmd_tail_bytes;
    logic [3:0]  cmd_gap;
    logic [31:0] cmd_seed;
    logic        cmd_busy, cmd_done;
    logic [15:0] frames_sent;
    logic        tvalid, tready, tlast;
    logic [63:0] tdata;
    logic [7:0]  tkeep;

    always #5 aclk = ~aclk;

    yolo_axis_mm2s_gen #(.TBITS(TBITS), .TBYTE(TBYTE)) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .cmd_start          (cmd_start),
        .cmd_len            (cmd_len),
        .cmd_tail_bytes     (cmd_tail_bytes),
        .cmd_gap            (cmd_gap),
        .cmd_seed           (cmd_seed),
        .cmd_busy           (cmd_busy),
        .cmd_done           (cmd_done),
        .frames_sent        (frames_sent),
        .M_AXIS_MM2S_TVALID (tvalid),
        .M_AXIS_MM2S_TREADY (tready),
        .M_AXIS_MM2S_TDATA  (tdata),
        .M_AXIS_MM2S_TKEEP  (tkeep),
        .M_AXIS_MM2S_TLAST  (tlast)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        int          gap;
    } beat_t;

    beat_t exp_q[$];
    int    exp_done_q[$];
    int    tests = 0;
    int    fails = 0;
    int    frames_model = 0;
    int    ready_pct = 100;
    bit    mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference: beat i lane k = seed + 2i + k; keep trimmed on the last beat only.
    task automatic model_push(input int len, input int tail, input int gap, input logic [31:0] seed);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            logic [31:0] l0;
            l0     = seed + 32'(2 * i);
            b.data = {l0 + 32'd1, l0};
            b.last = (i == len - 1);
            b.keep = (b.last && tail != 0) ? (8'hFF >> (8 - tail)) : 8'hFF;
            b.gap  = b.last ? 0 : gap;
            exp_q.push_back(b);
        end
        frames_model = (frames_model + 1) % 65536;
        exp_done_q.push_back(frames_model);
    endtask

    // Called just after a rising edge; returns just after the following one.
    task automatic pulse_start(input int len, input int tail, input int gap,
                               input logic [31:0] seed, input bit accept);
        cmd_len        = 16'(len);
        cmd_tail_bytes = 3'(tail);
        cmd_gap        = 4'(gap);
        cmd_seed       = seed;
        cmd_start      = 1'b1;
        if (accept) model_push(len, tail, gap, seed);
        @(posedge aclk); #1;
        cmd_start = 1'b0;
        if (accept && len != 0) begin
            chk("start_tvalid", 64'(tvalid), 64'd1);
            chk("start_busy", 64'(cmd_busy), 64'd1);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((cmd_busy || exp_q.size() != 0 || exp_done_q.size() != 0) && n < 3000) begin
            @(posedge aclk); #1;
            n++;
        end
        tests++;
        if (n >= 3000) begin
            fails++;
            $display("FAIL wait_idle: timeout, %0d beats and %0d dones outstanding",
                     exp_q.size(), exp_done_q.size());
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tvalid"}, 64'(tvalid), 64'd0);
        chk({tag, "_tlast"}, 64'(tlast), 64'd0);
        chk({tag, "_busy"}, 64'(cmd_busy), 64'd0);
        chk({tag, "_done"}, 64'(cmd_done), 64'd0);
        chk({tag, "_tdata"}, tdata, 64'd0);
        chk({tag, "_tkeep"}, 64'(tkeep), 64'd0);
        chk({tag, "_frames"}, 64'(frames_sent), 64'd0);
    endtask

    initial begin
        tready = 1'b0;
        forever begin
            @(posedge aclk); #1;
            tready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    initial begin
        beat_t       b;
        bit          stall_p, in_gap, want_done;
        int          low, exp_gap;
        logic [63:0] d_p;
        logic [7:0]  k_p;
        logic        l_p;
        stall_p = 0; in_gap = 0; want_done = 0; low = 0; exp_gap = 0;
        d_p = '0; k_p = '0; l_p = 1'b0;
        forever begin
            @(negedge aclk);
            if (!mon_en) begin
                stall_p = 0; in_gap = 0; want_done = 0;
                continue;
            end
            if (want_done) begin
                chk("done_after_last", 64'(cmd_done), 64'd1);
                want_done = 0;
            end
            if (cmd_done) begin
                if (exp_done_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL extra_done: got cmd_done, required no pending frame");
                end else begin
                    chk("frames_sent", 64'(frames_sent), 64'(exp_done_q.pop_front()));
                end
            end
            if (stall_p) begin
                chk("stall_tvalid", 64'(tvalid), 64'd1);
                chk("stall_tdata", tdata, d_p);
                chk("stall_tkeep", 64'(tkeep), 64'(k_p));
                chk("stall_tlast", 64'(tlast), 64'(l_p));
            end
            if (tvalid) begin
                if (in_gap) begin
                    chk("gap_cycles", 64'(low), 64'(exp_gap));
                    in_gap = 0;
                end
                if (tready) begin
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL extra_beat: got tdata 0x%0h, required no beat", tdata);
                    end else begin
                        b = exp_q.pop_front();
                        chk("tdata", tdata, b.data);
                        chk("tkeep", 64'(tkeep), 64'(b.keep));
                        chk("tlast", 64'(tlast), 64'(b.last));
                        if (b.last) want_done = 1;
                        else begin in_gap = 1; low = 0; exp_gap = b.gap; end
                    end
                end
            end else if (in_gap) begin
                low++;
            end
            stall_p = tvalid && !tready;
            d_p = tdata; k_p = tkeep; l_p = tlast;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_start = 1'b0; cmd_len = '0; cmd_tail_bytes = '0; cmd_gap = '0; cmd_seed = '0;
        repeat (3) @(posedge aclk);
        #1;
        chk_reset_vals("reset");
        aresetn = 1'b1;
        mon_en  = 1'b1;
        @(posedge aclk); #1;

        // Full-rate frame with literal expectations on the first beat.
        ready_pct = 100;
        pulse_start(4, 0, 0, 32'h100, 1);
        chk("t1_beat0_data", tdata, 64'h00000101_00000100);
        wait_idle();
        chk("t1_frames", 64'(frames_sent), 64'd1);

        // Partial last beat under heavy back-pressure.
        ready_pct = 30;
        pulse_start(3, 3, 0, 32'hDEAD_0000, 1);
        wait_idle();

        // Gapped frame.
        ready_pct = 100;
        pulse_start(5, 0, 2, 32'h0000_1000, 1);
        wait_idle();

        // Null frame then single-beat frame.
        pulse_start(0, 0, 0, 32'h1234_5678, 1);
        chk("null_done", 64'(cmd_done), 64'd1);
        chk("null_tvalid", 64'(tvalid), 64'd0);
        wait_idle();
        pulse_start(1, 5, 0, 32'hFFFF_FFFF, 1);
        chk("len1_tlast", 64'(tlast), 64'd1);
        wait_idle();

        // Start mid-frame is dropped.
        pulse_start(6, 0, 1, 32'hA000_0000, 1);
        repeat (3) begin @(posedge aclk); #1; end
        pulse_start(9, 2, 0, 32'hBAD0_0000, 0);
        wait_idle();

        // Start on the last handshake is dropped; start in the done cycle is taken.
        pulse_start(4, 2, 0, 32'h0000_2000, 1);
        repeat (3) begin @(posedge aclk); #1; end
        pulse_start(7, 0, 0, 32'hBAD1_0000, 0);
        chk("done_cycle_done", 64'(cmd_done), 64'd1);
        chk("done_cycle_busy", 64'(cmd_busy), 64'd0);
        pulse_start(3, 1, 0, 32'h0000_3000, 1);
        wait_idle();

        // Randomized frames.
        for (int n = 0; n < 20; n++) begin
            int len, tail, gap;
            logic [31:0] seed;
            len  = int'($urandom_range(0, 9));
            tail = int'($urandom_range(0, 7));
            gap  = int'($urandom_range(0, 3));
            seed = $urandom;
            ready_pct = int'($urandom_range(30, 100));
            pulse_start(len, tail, gap, seed, 1);
            wait_idle();
        end

        // Asynchronous reset during beat 2 of a long frame.
        ready_pct = 100;
        @(posedge aclk); #1;
        pulse_start(8, 0, 0, 32'h0000_4000, 1);
        repeat (2) begin @(posedge aclk); #1; end
        mon_en  = 1'b0;
        aresetn = 1'b0;
        #1;
        chk_reset_vals("midreset");
        exp_q.delete();
        exp_done_q.delete();
        frames_model = 0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        mon_en  = 1'b1;
        @(posedge aclk); #1;
        pulse_start(2, 0, 0, 32'h0000_5000, 1);
        wait_idle();
        chk("post_reset_frames", 64'(frames_sent), 64'd1);

        repeat (3) @(posedge aclk);
        #1;
        chk("beats_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
